contador_param: RTL and testbench

CONTADOR_PARAM -- requirements
Module: contador_param

---
 rtl/contador_param.sv | 69 ++++++
 tb/tb_contador_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// Parameterised up/down/step counter with parallel load,
// optional saturation, registered RCO and combinational TC.
module contador_param #(
  parameter int          WIDTH = 4,
  parameter int unsigned STEP  = 3,
  parameter bit          SAT   = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC
);

  localparam logic [WIDTH:0] ONE    = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX  = '1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("contador_param: WIDTH out of range");
  end
  if (STEP < 1 || 64'(STEP) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_step
    $error("contador_param: STEP out of range");
  end

  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   res;
  logic             bnd;
  logic [WIDTH-1:0] q_nxt;

  // Extra MSB of res is the carry (up) or borrow (down).
  always_comb begin
    ext = {1'b0, Q};
    res = ext;
    unique case (MODO)
      2'b00:   res = ext + ONE;
      2'b01:   res = ext - ONE;
      2'b10:   res = ext - STEP_X;
      default: res = {1'b0, D};
    endcase
  end

  assign bnd = ENB && (MODO != 2'b11) && res[WIDTH];
  assign TC  = bnd;

  always_comb begin
    q_nxt = Q;
    if (ENB) begin
      q_nxt = res[WIDTH-1:0];
      if (bnd && SAT) begin
        q_nxt = (MODO == 2'b00) ? MAX : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else begin
      Q   <= q_nxt;
      RCO <= bnd;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench: directed vector table, reset sequences
// and random traffic against a behavioural model (wrap + clamp).
module tb_contador_param;

  logic       clk;
  logic       rst_l;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       rco0, rco1, tc0, tc1;

  contador_param #(.WIDTH(4), .STEP(3), .SAT(1'b0)) u_wrap (
    .CLK(clk), .RESET_L(rst_l), .ENB(enb), .MODO(modo),
    .D(d), .Q(q0), .RCO(rco0), .TC(tc0)
  );

  contador_param #(.WIDTH(4), .STEP(3), .SAT(1'b1)) u_sat (
    .CLK(clk), .RESET_L(rst_l), .ENB(enb), .MODO(modo),
    .D(d), .Q(q1), .RCO(rco1), .TC(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       tc;
    logic [3:0] q;
    logic       rco;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  int   mq0, mq1;
  logic mr0, mr1;
  logic et0, et1;
  logic [3:0] sq0, sq1;
  logic sr0, sr1, st0, st1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mtc(input logic en, input logic [1:0] mode,
                               input int q);
    if (!en) return 1'b0;
    case (mode)
      2'd0:    return q == 15;
      2'd1:    return q == 0;
      2'd2:    return q < 3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input bit sat, input logic en,
                            input logic [1:0] mode, input logic [3:0] dd,
                            inout int q, output logic rco);
    int v;
    rco = 1'b0;
    v = q;
    if (en) begin
      case (mode)
        2'd0: begin
          v = q + 1;
          if (v > 15) begin rco = 1'b1; v = sat ? 15 : 0; end
        end
        2'd1: begin
          v = q - 1;
          if (v < 0) begin rco = 1'b1; v = sat ? 0 : v + 16; end
        end
        2'd2: begin
          v = q - 3;
          if (v < 0) begin rco = 1'b1; v = sat ? 0 : v + 16; end
        end
        default: v = int'(dd);
      endcase
    end
    q = v;
  endtask

  task automatic cycle(input logic en, input logic [1:0] mode,
                       input logic [3:0] dd);
    @(negedge clk);
    enb = en; modo = mode; d = dd;
    #1;
    st0 = tc0; st1 = tc1;
    et0 = mtc(en, mode, mq0);
    et1 = mtc(en, mode, mq1);
    @(posedge clk);
    #1;
    sq0 = q0; sr0 = rco0; sq1 = q1; sr1 = rco1;
    model_step(1'b0, en, mode, dd, mq0, mr0);
    model_step(1'b1, en, mode, dd, mq1, mr1);
  endtask

  task automatic chk_sat_model(input string nm);
    chk({nm, "_sat_tc"}, 32'(st1), 32'(et1));
    chk({nm, "_sat_q"}, 32'(sq1), 32'(mq1));
    chk({nm, "_sat_rco"}, 32'(sr1), 32'(mr1));
  endtask

  task automatic chk_all_model(input string nm);
    chk({nm, "_wrap_tc"}, 32'(st0), 32'(et0));
    chk({nm, "_wrap_q"}, 32'(sq0), 32'(mq0));
    chk({nm, "_wrap_rco"}, 32'(sr0), 32'(mr0));
    chk_sat_model(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int qs[6];
    int ps[6];
    enb = 1'b0; modo = 2'd0; d = 4'd0;
    mq0 = 0; mq1 = 0;

    // reset state
    rst_l = 1'b1;
    #1 rst_l = 1'b0;
    #2;
    chk("rst_wrap_q", 32'(q0), 32'd0);
    chk("rst_wrap_rco", 32'(rco0), 32'd0);
    chk("rst_sat_q", 32'(q1), 32'd0);
    chk("rst_tc", 32'(tc0), 32'd0);
    #9 rst_l = 1'b1;

    // directed table for the wrapping instance
    vecs.push_back('{1'b1, 2'd3, 4'd0, 1'b0, 4'd0, 1'b0});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 2'd0, 4'd5, 1'(i == 15),
                       4'((i + 1) % 16), 1'(i == 15)});
    vecs.push_back('{1'b1, 2'd3, 4'd0, 1'b0, 4'd0, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 4'd0, 1'b1, 4'd15, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 4'd0, 1'b0, 4'd14, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 4'd0, 1'b0, 4'd13, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 4'd0, 1'b0, 4'd0, 1'b0});
    qs = '{13, 10, 7, 4, 1, 14};
    ps = '{0, 13, 10, 7, 4, 1};
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b1, 2'd2, 4'd0, 1'(ps[i] < 3),
                       4'(qs[i]), 1'(ps[i] < 3)});
    for (int m = 0; m < 4; m++)
      vecs.push_back('{1'b0, 2'(m), 4'bxxxx, 1'b0, 4'd14, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 4'b1010, 1'b0, 4'd10, 1'b0});

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].mode, vecs[i].d);
      chk($sformatf("vec%0d_tc", i), 32'(st0), 32'(vecs[i].tc));
      chk($sformatf("vec%0d_q", i), 32'(sq0), 32'(vecs[i].q));
      chk($sformatf("vec%0d_rco", i), 32'(sr0), 32'(vecs[i].rco));
      chk_sat_model($sformatf("vec%0d", i));
    end

    // clamping: load 14 then count up three times
    cycle(1'b1, 2'd3, 4'd14);
    cycle(1'b1, 2'd0, 4'd0);
    chk("clamp1_q", 32'(sq1), 32'd15);
    chk("clamp1_rco", 32'(sr1), 32'd0);
    cycle(1'b1, 2'd0, 4'd0);
    chk("clamp2_q", 32'(sq1), 32'd15);
    chk("clamp2_rco", 32'(sr1), 32'd1);
    chk("clamp2_wrap_q", 32'(sq0), 32'd0);
    cycle(1'b1, 2'd0, 4'd0);
    chk("clamp3_q", 32'(sq1), 32'd15);
    chk("clamp3_rco", 32'(sr1), 32'd1);
    chk_all_model("clamp3");

    // short reset pulse while Q=9
    cycle(1'b1, 2'd3, 4'd9);
    chk("pre_rst_q", 32'(sq0), 32'd9);
    rst_l = 1'b0;
    #1;
    chk("async_rst_q9", 32'(q0), 32'd0);
    chk("async_rst_q9_sat", 32'(q1), 32'd0);
    mq0 = 0; mq1 = 0;
    #2 rst_l = 1'b1;

    // reset during an RCO pulse, held across an edge
    cycle(1'b1, 2'd2, 4'd0);
    chk("pulse_q", 32'(sq0), 32'd13);
    chk("pulse_rco", 32'(sr0), 32'd1);
    chk("pulse_sat_rco", 32'(sr1), 32'd1);
    rst_l = 1'b0;
    #1;
    chk("abort_q", 32'(q0), 32'd0);
    chk("abort_rco", 32'(rco0), 32'd0);
    chk("abort_sat_rco", 32'(rco1), 32'd0);
    enb = 1'b1; modo = 2'd0;
    @(posedge clk);
    #1;
    chk("held_q", 32'(q0), 32'd0);
    chk("held_rco", 32'(rco0), 32'd0);
    rst_l = 1'b1;
    mq0 = 0; mq1 = 0;
    cycle(1'b1, 2'd0, 4'd0);
    chk("release_q", 32'(sq0), 32'd1);
    chk("release_rco", 32'(sr0), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
      chk_all_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
